// File: rtl/pxs_cursor_ovl_pkg.sv
// Shared definitions for the console pixel stream and the cursor overlay.
// Latency: n/a (types, field positions and encodings only).
// Backpressure: n/a.
package pxs_cursor_ovl_pkg;

  // Pixel stream word layout (RGBStr), LSB first.
  localparam int PXS_W       = 26;
  localparam int PXS_ACT     = 0;
  localparam int PXS_VS      = 1;
  localparam int PXS_HS      = 2;
  localparam int PXS_YC_LSB  = 3;
  localparam int PXS_YC_MSB  = 12;
  localparam int PXS_XC_LSB  = 13;
  localparam int PXS_XC_MSB  = 22;
  localparam int PXS_R       = 23;
  localparam int PXS_G       = 24;
  localparam int PXS_B       = 25;
  localparam int PXS_RGB_LSB = 23;
  localparam int PXS_RGB_MSB = 25;

  // Same layout as a packed struct; rgb[0] is R, rgb[2] is B.
  typedef struct packed {
    logic [2:0] rgb;
    logic [9:0] xc;
    logic [9:0] yc;
    logic       hs;
    logic       vs;
    logic       act;
  } pxs_t;

  // tcursor[1:0] shape encodings.
  typedef enum logic [1:0] {
    CUR_OFF   = 2'b00,
    CUR_BLOCK = 2'b01,
    CUR_ULINE = 2'b10,
    CUR_BAR   = 2'b11
  } cur_shape_t;

  // tcursor bit positions for blink enable and draw mode.
  localparam int TC_BLINK = 2;
  localparam int TC_MODE  = 3;

  // Draw modes carried in tcursor[3].
  localparam logic CUR_MODE_INV   = 1'b0;
  localparam logic CUR_MODE_WHITE = 1'b1;

endpackage

// File: rtl/pxs_frame_blink.sv
// Frame-event detector and blink phase generator driven by the stream's VS bit.
// Latency: o_fe is combinational from i_vs; o_phase updates one cycle after a frame event.
// Backpressure: none; observes the stream every cycle.
// Ports: px_clk, rst_n (async, active low), i_vs (VS bit of the stream),
//        o_fe (VS rising edge this cycle), o_phase (1 = blink "on" half-period).
module pxs_frame_blink #(
  parameter int BLINK_FRAMES = 16
) (
  input  logic px_clk,
  input  logic rst_n,
  input  logic i_vs,
  output logic o_fe,
  output logic o_phase
);

  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(BLINK_FRAMES - 1);

  logic           r_vs_prev;
  logic [FCW-1:0] r_fcnt;
  logic           r_phase;

  assign o_fe    = i_vs & ~r_vs_prev;
  assign o_phase = r_phase;

  // The timer runs regardless of whether any consumer has blinking enabled.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev <= 1'b0;
      r_fcnt    <= '0;
      r_phase   <= 1'b1;
    end else begin
      r_vs_prev <= i_vs;
      if (o_fe) begin
        if (r_fcnt == FCNT_LAST) begin
          r_fcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pxs_cursor_ovl.sv
// Text-console cursor overlay (block / underline / bar, invert or force-white) on the RGBStr stream.
// Latency: exactly 2 px_clk cycles on every field.
// Backpressure: none; one pixel in and one pixel out every cycle.
// Ports: px_clk, rst_n (async, active low), RGBStr_i / RGBStr_o (26-bit stream),
//        pos_x / pos_y (cursor cell), tcursor ([1:0] shape, [2] blink enable, [3] force white).
module pxs_cursor_ovl
  import pxs_cursor_ovl_pkg::*;
#(
  parameter int GW           = 8,
  parameter int GH           = 8,
  parameter int COLS         = 80,
  parameter int ROWS         = 60,
  parameter int BLINK_FRAMES = 16,
  parameter int BAR          = 2
) (
  input  logic             px_clk,
  input  logic             rst_n,
  input  logic [PXS_W-1:0] RGBStr_i,
  input  logic [6:0]       pos_x,
  input  logic [6:0]       pos_y,
  input  logic [3:0]       tcursor,
  output logic [PXS_W-1:0] RGBStr_o
);

  localparam int GWL = $clog2(GW);
  localparam int GHL = $clog2(GH);
  localparam logic [31:0] BAR_U   = 32'(BAR);
  localparam logic [31:0] ULINE_Y = 32'(GH - BAR);
  localparam logic [31:0] COLS_U  = 32'(COLS);
  localparam logic [31:0] ROWS_U  = 32'(ROWS);

  pxs_t w_in;
  assign w_in = pxs_t'(RGBStr_i);

  // Frame event and blink phase.
  logic w_fe;
  logic w_phase;

  pxs_frame_blink #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .px_clk  (px_clk),
    .rst_n   (rst_n),
    .i_vs    (w_in.vs),
    .o_fe    (w_fe),
    .o_phase (w_phase)
  );

  // Shadow copies of the cursor controls, taken once per frame.
  logic [6:0] r_sh_x;
  logic [6:0] r_sh_y;
  logic [3:0] r_sh_tc;

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_x  <= '0;
      r_sh_y  <= '0;
      r_sh_tc <= '0;
    end else if (w_fe) begin
      r_sh_x  <= pos_x;
      r_sh_y  <= pos_y;
      r_sh_tc <= tcursor;
    end
  end

  // The pixel carrying the VS rise is already judged with the freshly latched values.
  logic [6:0] w_cur_x;
  logic [6:0] w_cur_y;
  logic [3:0] w_cur_tc;

  assign w_cur_x  = w_fe ? pos_x   : r_sh_x;
  assign w_cur_y  = w_fe ? pos_y   : r_sh_y;
  assign w_cur_tc = w_fe ? tcursor : r_sh_tc;

  // Cell origin and bounds; 11-bit compares so ax+GW never wraps.
  logic [9:0]     w_ax;
  logic [9:0]     w_ay;
  logic [10:0]    w_ax_end;
  logic [10:0]    w_ay_end;
  logic           w_inx;
  logic           w_iny;
  logic [GWL-1:0] w_dx;
  logic [GHL-1:0] w_dy;

  assign w_ax     = 10'(w_cur_x) << GWL;
  assign w_ay     = 10'(w_cur_y) << GHL;
  assign w_ax_end = {1'b0, w_ax} + 11'(GW);
  assign w_ay_end = {1'b0, w_ay} + 11'(GH);
  assign w_inx    = ({1'b0, w_in.xc} >= {1'b0, w_ax}) && ({1'b0, w_in.xc} < w_ax_end);
  assign w_iny    = ({1'b0, w_in.yc} >= {1'b0, w_ay}) && ({1'b0, w_in.yc} < w_ay_end);
  assign w_dx     = w_in.xc[GWL-1:0] - w_ax[GWL-1:0];
  assign w_dy     = w_in.yc[GHL-1:0] - w_ay[GHL-1:0];

  logic w_shape_hit;

  always_comb begin
    w_shape_hit = 1'b0;
    case (w_cur_tc[1:0])
      CUR_BLOCK: w_shape_hit = 1'b1;
      CUR_ULINE: w_shape_hit = (32'(w_dy) >= ULINE_Y);
      CUR_BAR:   w_shape_hit = (32'(w_dx) < BAR_U);
      default:   w_shape_hit = 1'b0;
    endcase
  end

  logic w_visible;
  logic w_in_range;
  logic w_draw;

  assign w_visible  = w_phase | ~w_cur_tc[TC_BLINK];
  assign w_in_range = (32'(w_cur_x) < COLS_U) && (32'(w_cur_y) < ROWS_U);
  assign w_draw     = w_inx & w_iny & w_shape_hit & w_in.act & w_visible & w_in_range;

  // Stage 1: stream plus the draw decision and mode.
  pxs_t r_s1_pix;
  logic r_s1_draw;
  logic r_s1_mode;

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_pix  <= '0;
      r_s1_draw <= 1'b0;
      r_s1_mode <= 1'b0;
    end else begin
      r_s1_pix  <= w_in;
      r_s1_draw <= w_draw;
      r_s1_mode <= w_cur_tc[TC_MODE];
    end
  end

  // Stage 2: colour substitution; only RGB is ever modified.
  pxs_t w_s2_pix;
  pxs_t r_s2_pix;

  always_comb begin
    w_s2_pix = r_s1_pix;
    if (r_s1_draw) begin
      w_s2_pix.rgb = (r_s1_mode == CUR_MODE_WHITE) ? 3'b111 : ~r_s1_pix.rgb;
    end
  end

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_pix <= '0;
    end else begin
      r_s2_pix <= w_s2_pix;
    end
  end

  assign RGBStr_o = r_s2_pix;

endmodule

// File: tb/tb_pxs_cursor_ovl.sv
// Self-checking bench for pxs_cursor_ovl: scoreboard queue filled by the driver, drained by a monitor.
// Frames cover a 32x16 pixel window around the cursor cells; per-frame changed-pixel counts are hand values.
module tb_pxs_cursor_ovl;

  localparam int BF = 2;

  logic        px_clk = 1'b0;
  logic        rst_n;
  logic [25:0] RGBStr_i;
  logic [25:0] RGBStr_o;
  logic [6:0]  pos_x;
  logic [6:0]  pos_y;
  logic [3:0]  tcursor;

  always #5 px_clk = ~px_clk;

  pxs_cursor_ovl #(
    .GW(8), .GH(8), .COLS(80), .ROWS(60), .BLINK_FRAMES(BF), .BAR(2)
  ) dut (
    .px_clk   (px_clk),
    .rst_n    (rst_n),
    .RGBStr_i (RGBStr_i),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .tcursor  (tcursor),
    .RGBStr_o (RGBStr_o)
  );

  typedef struct {
    logic [25:0] exp;
    logic [2:0]  in_rgb;
    int          due;
  } sb_t;

  sb_t q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  hits = 0;

  always @(posedge px_clk) cyc <= cyc + 1;

  // Monitor: compare every output pixel whose expected value is due this cycle.
  always @(negedge px_clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      sb_t e;
      e = q.pop_front();
      checks++;
      if (RGBStr_o !== e.exp) begin
        failures++;
        $display("FAIL pix cyc=%0d got=%h exp=%h", cyc, RGBStr_o, e.exp);
      end
      if (RGBStr_o[0] && RGBStr_o[25:23] != e.in_rgb) hits++;
    end
  end

  // Reference state for the expected-value model.
  logic       m_vsprev;
  int         m_fcnt;
  logic       m_phase;
  logic [6:0] m_px;
  logic [6:0] m_py;
  logic [3:0] m_tc;

  task automatic model_reset();
    m_vsprev = 1'b0;
    m_fcnt   = 0;
    m_phase  = 1'b1;
    m_px     = '0;
    m_py     = '0;
    m_tc     = '0;
  endtask

  task automatic model_px(input logic [25:0] in, output logic [25:0] out);
    logic       fe, h, draw;
    int         xc, yc, ax, ay, dx, dy;
    logic [2:0] rgb;
    rgb = in[25:23];
    xc  = int'(in[22:13]);
    yc  = int'(in[12:3]);
    fe  = in[1] && !m_vsprev;
    m_vsprev = in[1];
    if (fe) begin
      m_px = pos_x;
      m_py = pos_y;
      m_tc = tcursor;
      if (m_fcnt == BF - 1) begin
        m_fcnt  = 0;
        m_phase = !m_phase;
      end else begin
        m_fcnt++;
      end
    end
    ax = int'(m_px) * 8;
    ay = int'(m_py) * 8;
    dx = xc - ax;
    dy = yc - ay;
    case (m_tc[1:0])
      2'b01:   h = 1'b1;
      2'b10:   h = (dy >= 6);
      2'b11:   h = (dx < 2);
      default: h = 1'b0;
    endcase
    draw = (xc >= ax) && (xc < ax + 8) && (yc >= ay) && (yc < ay + 8) && h && in[0]
           && (m_phase || !m_tc[2]) && (m_px < 80) && (m_py < 60);
    out = in;
    if (draw) out[25:23] = m_tc[3] ? 3'b111 : ~rgb;
  endtask

  task automatic drive(input logic act, input logic vs, input logic hs,
                       input int yc, input int xc, input logic [2:0] rgb, input bit push);
    logic [25:0] v, e;
    @(posedge px_clk);
    #1;
    v = {rgb, 10'(xc), 10'(yc), hs, vs, act};
    RGBStr_i = v;
    if (push) begin
      model_px(v, e);
      q.push_back('{exp: e, in_rgb: rgb, due: cyc + 2});
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge px_clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_%s pending=%0d required=0", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_hits(input int exp, input string name);
    drain(name);
    checks++;
    if (hits != exp) begin
      failures++;
      $display("FAIL hits_%s got=%0d exp=%0d", name, hits, exp);
    end
    hits = 0;
  endtask

  task automatic vblank(input logic [2:0] rgb);
    drive(1'b0, 1'b0, 1'b0, 0, 0, rgb, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 0, 0, rgb, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 0, 0, rgb, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 0, 0, rgb, 1'b1);
  endtask

  task automatic rows(input int y0, input int y1, input logic [2:0] rgb,
                      input int blank_col, input int chg_row, input logic [6:0] chg_px);
    for (int y = y0; y <= y1; y++) begin
      if (y == chg_row) pos_x = chg_px;
      for (int x = 16; x < 48; x++) drive(x != blank_col, 1'b0, 1'b0, y, x, rgb, 1'b1);
      drive(1'b0, 1'b0, 1'b1, y, 48, rgb, 1'b1);
    end
  endtask

  task automatic frame(input logic [2:0] rgb, input int blank_col, input int chg_row,
                       input logic [6:0] chg_px, input int exp_hits, input string name);
    vblank(rgb);
    rows(12, 27, rgb, blank_col, chg_row, chg_px);
    check_hits(exp_hits, name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    RGBStr_i = '0;
    pos_x    = '0;
    pos_y    = '0;
    tcursor  = '0;
    model_reset();
    repeat (3) @(posedge px_clk);
    #1;
    checks++;
    if (RGBStr_o !== 26'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", RGBStr_o);
    end
    rst_n = 1'b1;

    // Block, underline, bar.
    pos_x = 7'd3; pos_y = 7'd2; tcursor = 4'b0001;
    frame(3'b000, -1, -1, 7'd0, 64, "block");
    tcursor = 4'b0010;
    frame(3'b010, -1, -1, 7'd0, 16, "uline");
    tcursor = 4'b0011;
    frame(3'b010, -1, -1, 7'd0, 16, "bar");

    // Blink: visible, visible, hidden, hidden, visible.
    tcursor = 4'b0101;
    frame(3'b000, -1, -1, 7'd0, 64, "blink0");
    frame(3'b000, -1, -1, 7'd0, 64, "blink1");
    frame(3'b000, -1, -1, 7'd0, 0,  "blink2");
    frame(3'b000, -1, -1, 7'd0, 0,  "blink3");
    frame(3'b000, -1, -1, 7'd0, 64, "blink4");
    tcursor = 4'b0001;
    frame(3'b000, -1, -1, 7'd0, 64, "noblink_a");
    frame(3'b000, -1, -1, 7'd0, 64, "noblink_b");

    // Force white with a blanking column inside the cell.
    tcursor = 4'b1001;
    frame(3'b101, 26, -1, 7'd0, 56, "white");

    // Mid-frame position change only takes effect at the next frame.
    tcursor = 4'b0001;
    frame(3'b000, -1, 20, 7'd4, 64, "latch_mid");
    frame(3'b000, -1, -1, 7'd0, 64, "latch_next");
    pos_x = 7'd80;
    frame(3'b000, -1, -1, 7'd0, 0, "col_range");
    pos_x = 7'd3; pos_y = 7'd60;
    frame(3'b000, -1, -1, 7'd0, 0, "row_range");

    // Reset mid-frame.
    pos_y = 7'd2;
    vblank(3'b000);
    rows(12, 13, 3'b000, -1, -1, 7'd0);
    check_hits(0, "pre_rst");
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (RGBStr_o !== 26'd0) begin
      failures++;
      $display("FAIL rst_async got=%h exp=0", RGBStr_o);
    end
    model_reset();
    for (int x = 16; x < 20; x++) drive(1'b1, 1'b0, 1'b0, 14, x, 3'b000, 1'b0);
    checks++;
    if (RGBStr_o !== 26'd0) begin
      failures++;
      $display("FAIL rst_hold got=%h exp=0", RGBStr_o);
    end
    @(posedge px_clk);
    #1;
    rst_n = 1'b1;
    rows(14, 27, 3'b000, -1, -1, 7'd0);
    check_hits(0, "rst_no_cursor");
    frame(3'b000, -1, -1, 7'd0, 64, "post_rst_fe");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pxs_cursor_ovl.md
# pxs_cursor_ovl

Parametrised cursor overlay for the 26-bit pixel stream (RGBStr) of the text console. It overlays a block, underline or vertical-bar cursor on one character cell and supports an inverting or forced-white draw mode. Blinking is timed from the stream's own frame boundaries. Cursor position and type are latched once per frame, so the cursor never tears mid-frame. The block sits after the text renderer and before the VGA output stage, with two cycles of latency.

## Interface
- `GW`, 8, glyph cell width in pixels; power of 2, 4..16
- `GH`, 8, glyph cell height in pixels; power of 2, 4..16
- `COLS`, 80, text columns; `pos_x` values ≥ COLS suppress the cursor
- `ROWS`, 60, text rows; `pos_y` values ≥ ROWS suppress the cursor
- `BLINK_FRAMES`, 16, blink half-period in frames; ≥ 1
- `BAR`, 2, thickness in pixels of the underline and bar shapes; 1..min(GW,GH)

Ports (clock and reset first):
- `px_clk`  in  1  pixel clock; all logic is on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `RGBStr_i`  in  26  input stream: Active[0], VS[1], HS[2], YC[12:3], XC[22:13], R[23], G[24], B[25]
- `pos_x`  in  7  cursor column
- `pos_y`  in  7  cursor row
- `tcursor`  in  4  cursor type:
  - [1:0] shape: 00 off, 01 block, 10 underline, 11 vertical bar
  - [2] blink enable
  - [3] draw mode: 0 = invert, 1 = force white
- `RGBStr_o`  out  26  output stream, same field layout as `RGBStr_i`

## Operation
- **Frame event.** `fe` is the rising edge of VS. It is detected against a registered copy of the previous VS bit.
- **Latching at `fe`.**
  - `pos_x`, `pos_y` and `tcursor` are copied into shadow registers.
  - Only the shadow registers are used for drawing.
  - Changes to the inputs between frame events have no visible effect until the next `fe`.
- **Blink timer.**
  - `fcnt` counts frame events from 0 to BLINK_FRAMES−1.
  - When a frame event arrives with `fcnt` at BLINK_FRAMES−1, `fcnt` wraps to 0 and `phase` toggles.
  - `phase` = 1 means the cursor is visible.
  - When shadow `tcursor[2]` = 0, `phase` is ignored and the cursor is treated as always visible.
- **Cell geometry.**
  - ax = pos_x·GW and ay = pos_y·GH, each computed in 10 bits using shifts by log2(GW) and log2(GH).
  - inx = XC ≥ ax and XC < ax+GW.
  - iny = YC ≥ ay and YC < ay+GH.
  - dx = XC − ax and dy = YC − ay, each log2 wide.
  - Comparisons use 11 bits so that ax+GW cannot wrap.
- **Shape hit.** hit = inx ∧ iny ∧ one of the following:
  - block: always
  - underline: dy ≥ GH−BAR
  - bar: dx < BAR
  - off: never
- **Draw.** draw = hit ∧ Active ∧ visible ∧ pos_x<COLS ∧ pos_y<ROWS, where visible = phase ∨ ¬tcursor[2] (shadow values).
- **Output colour.**
  - draw = 0: RGB passes through unchanged.
  - draw = 1, mode 0: output is ~RGB.
  - draw = 1, mode 1: output is 3'b111.
- **Non-RGB fields.** Active, VS, HS, XC and YC pass through delayed only, never modified.

## Timing
- Pipeline latency is exactly 2 cycles on every field.
  - Stage 1 registers `draw` together with the input stream.
  - Stage 2 registers the output.
- **Reset values.**
  - `RGBStr_o` = 0
  - all pipeline registers = 0
  - `fcnt` = 0
  - `phase` = 1
  - shadow position = 0
  - shadow `tcursor` = 4'b0000, so the cursor is off until the first `fe`
- **Shadow timing.** Shadow registers update in the same cycle `fe` is detected. The pixel carrying the VS rise is already judged with the new values; VS is in blanking, so there is no visible effect.
- **Reset mid-frame.** The output reads 0 while reset is asserted. After release, the stream resumes with the 2-cycle latency. No cursor is drawn until the next `fe`.
- **BLINK_FRAMES = 1.** `phase` toggles on every frame.
- **Simultaneous events.** A frame event and a change of `tcursor` in the same cycle: the new value is latched and the timer still advances.
- **Blink enable does not freeze the timer.** `fcnt` and `phase` keep running while blink is disabled.

## Structure
- Field position defines (Active, VS, HS, YC, XC, R, G, B, RGB, VGA) come from the shared `Pxs.vh` include, extended with `PXS_W` = 26.
- Shape and mode encodings are added to `Pxs.vh` as constants `CUR_OFF`, `CUR_BLOCK`, `CUR_ULINE`, `CUR_BAR`.
- Sub-module `pxs_frame_blink`:
  - takes the VS bit, `px_clk` and `rst_n`
  - outputs `fe` and `phase`
  - takes parameter `BLINK_FRAMES`
  - is reusable by the text renderer for attribute blinking

## Test plan
- **Block cursor.** pos=(3,2), tcursor=4'b0001, input RGB=3'b000 on active pixels. Expect RGB=3'b111 exactly for XC 24..31 and YC 16..23, two cycles after each input pixel; all other pixels stay 0.
- **Underline.** tcursor=4'b0010, BAR=2, GH=8. Expect only YC 22..23 of the cell to be inverted. **Bar:** tcursor=4'b0011. Expect only XC 24..25 to be inverted.
- **Blink.** BLINK_FRAMES=2, tcursor=4'b0101. Expect the cursor visible on frames 0–1, hidden on frames 2–3, and visible again on frame 4. Clearing bit 2 makes it visible on every frame.
- **Force white.** tcursor=4'b1001 on input RGB=3'b101. Expect 3'b111 inside the cell. Blanking pixels (Active=0) inside the cell's coordinates pass through unchanged.
- **Latching and range.** Change `pos_x` from 3 to 4 mid-frame: the cursor stays at column 3 until the next VS rise. pos_x=80: no cursor is drawn anywhere.
- **Reset.** Assert `rst_n`=0 mid-frame. Expect `RGBStr_o`=0 immediately (asynchronous). After release, XC, YC, HS and VS equal the input delayed 2 cycles, and no cursor appears before the first `fe`.
